// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle around the RV32I decode stage: fetch offers instructions,
// execute consumes decoded entries, and flush travels with the fetch side.
interface decode_stage_if #(
  parameter int XLEN            = 32,
  parameter int ALU_FUNCT_WIDTH = 4
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_instr;
  logic [XLEN-1:0]            in_pc;
  logic                       ctrl_override;

  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_pc;
  logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
  logic [4:0]                 rs1;
  logic [4:0]                 rs2;
  logic [4:0]                 rd;
  logic [XLEN-1:0]            immed;
  logic                       use_imm;
  logic                       rd_we;
  logic                       illegal;

  // master drives instructions in and consumes results; slave is the decode stage
  modport master (
    output flush, in_valid, in_instr, in_pc, ctrl_override, out_ready,
    input  in_ready, out_valid, out_pc, alu_funct, rs1, rs2, rd, immed,
           use_imm, rd_we, illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, ctrl_override, out_ready,
    output in_ready, out_valid, out_pc, alu_funct, rs1, rs2, rd, immed,
           use_imm, rd_we, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode of the offered word, captured
// into a two-entry skid buffer so execute back-pressure never reaches fetch combinationally.
module decode_stage #(
  parameter int XLEN            = 32,
  parameter int ALU_FUNCT_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD  = ALU_FUNCT_WIDTH'(0);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB  = ALU_FUNCT_WIDTH'(1);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL  = ALU_FUNCT_WIDTH'(2);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT  = ALU_FUNCT_WIDTH'(3);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLTU = ALU_FUNCT_WIDTH'(4);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR  = ALU_FUNCT_WIDTH'(5);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL  = ALU_FUNCT_WIDTH'(6);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA  = ALU_FUNCT_WIDTH'(7);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR   = ALU_FUNCT_WIDTH'(8);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND  = ALU_FUNCT_WIDTH'(9);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [ALU_FUNCT_WIDTH-1:0] alu;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [XLEN-1:0]            immed;
    logic                       use_imm;
    logic                       rd_we;
    logic                       illegal;
  } entry_t;

  function automatic logic [ALU_FUNCT_WIDTH-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]                 opcode;
  logic [2:0]                 funct3;
  logic [6:0]                 funct7;
  logic [ALU_FUNCT_WIDTH-1:0] alu_sel;
  logic                       is_arith;
  logic                       bad_enc;
  logic                       use_imm;
  logic                       writes;
  logic [XLEN-1:0]            imm;
  entry_t                     dec;

  always_comb begin
    opcode   = bus.in_instr[6:0];
    funct3   = bus.in_instr[14:12];
    funct7   = bus.in_instr[31:25];
    alu_sel  = ALU_ADD;
    is_arith = 1'b0;
    bad_enc  = 1'b0;
    use_imm  = 1'b1;
    writes   = 1'b1;
    imm      = '0;
    case (opcode)
      OPC_OP_IMM: begin
        is_arith = 1'b1;
        imm      = XLEN'($signed(bus.in_instr[31:20]));
        case (funct3)
          3'b001: begin
            imm     = XLEN'(bus.in_instr[24:20]);
            alu_sel = ALU_SLL;
            bad_enc = (funct7 != F7_BASE);
          end
          3'b101: begin
            imm = XLEN'(bus.in_instr[24:20]);
            if (funct7 == F7_BASE)     alu_sel = ALU_SRL;
            else if (funct7 == F7_ALT) alu_sel = ALU_SRA;
            else                       bad_enc = 1'b1;
          end
          default: alu_sel = base_op(funct3);
        endcase
      end
      OPC_OP: begin
        is_arith = 1'b1;
        use_imm  = 1'b0;
        if (funct7 == F7_BASE)                        alu_sel = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) alu_sel = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) alu_sel = ALU_SRA;
        else                                          bad_enc = 1'b1;
      end
      OPC_LOAD, OPC_JALR: imm = XLEN'($signed(bus.in_instr[31:20]));
      OPC_STORE: begin
        imm    = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
        writes = 1'b0;
      end
      OPC_BRANCH: begin
        imm     = XLEN'($signed({bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25],
                                 bus.in_instr[11:8], 1'b0}));
        use_imm = 1'b0;
        writes  = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      OPC_JAL: imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20],
                                    bus.in_instr[30:21], 1'b0}));
      default: bad_enc = 1'b1;
    endcase

    // Illegal words still travel down the pipe, but as a harmless non-writing ADD
    dec.pc      = bus.in_pc;
    dec.rs1     = bus.in_instr[19:15];
    dec.rs2     = bus.in_instr[24:20];
    dec.rd      = bus.in_instr[11:7];
    dec.illegal = bad_enc;
    dec.alu     = (is_arith && !bus.ctrl_override && !bad_enc) ? alu_sel : ALU_ADD;
    dec.immed   = bad_enc ? '0 : imm;
    dec.use_imm = use_imm;
    dec.rd_we   = writes && !bad_enc && (bus.in_instr[11:7] != 5'd0);
  end

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // Producers hold valid and data until the transfer; in_ready is driven only by the
  // registered skid state and flush, so it never depends on out_ready.
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, consume;

  assign bus.in_ready = !skid_valid_q && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = main_valid_q && bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume || !main_valid_q) begin
      // Skid is only ever valid while main is, and accept is blocked while skid is full
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.out_pc    = main_q.pc;
  assign bus.alu_funct = main_q.alu;
  assign bus.rs1       = main_q.rs1;
  assign bus.rs2       = main_q.rs2;
  assign bus.rd        = main_q.rd;
  assign bus.immed     = main_q.immed;
  assign bus.use_imm   = main_q.use_imm;
  assign bus.rd_we     = main_q.rd_we;
  assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, streaming, skid ordering,
// flush and mid-transfer reset, each checked against hand-computed values.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int AFW  = 4;

  localparam logic [AFW-1:0] A_ADD = 4'd0;
  localparam logic [AFW-1:0] A_SUB = 4'd1;
  localparam logic [AFW-1:0] A_XOR = 4'd5;
  localparam logic [AFW-1:0] A_SRA = 4'd7;

  typedef struct {
    logic [31:0]    instr;
    logic           ovr;
    logic [AFW-1:0] alu;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic [31:0]    imm;
    logic           use_imm;
    logic           rd_we;
    logic           illegal;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN), .ALU_FUNCT_WIDTH(AFW)) bus ();

  decode_stage #(.XLEN(XLEN), .ALU_FUNCT_WIDTH(AFW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.ctrl_override = 1'b0; bus.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h0000_0100);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.immed !== '0 ||
        bus.alu_funct !== '0 || bus.rd_we !== 1'b0 || bus.illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b pc=%h imm=%h alu=%h we=%b ill=%b want all 0",
               bus.out_valid, bus.out_pc, bus.immed, bus.alu_funct, bus.rd_we, bus.illegal);
    end
    drive(1'b0, 32'h0, '0);
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_idle: valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_decode();
    vec_t vecs [12];
    vecs[0]  = '{32'hFFF10093, 1'b0, A_ADD, 5'd2,  5'd31, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{32'h41F25193, 1'b0, A_SRA, 5'd4,  5'd31, 5'd3,  32'h0000001F, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{32'h40020093, 1'b0, A_ADD, 5'd4,  5'd0,  5'd1,  32'h00000400, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'hFE532E23, 1'b0, A_ADD, 5'd6,  5'd5,  5'd28, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'hFE000EE3, 1'b0, A_ADD, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 1'b0, A_ADD, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'h40000033, 1'b1, A_ADD, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h40000033, 1'b0, A_SUB, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h123452B7, 1'b0, A_ADD, 5'd8,  5'd3,  5'd5,  32'h12345000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{32'hFF9FF0EF, 1'b0, A_ADD, 5'd31, 5'd25, 5'd1,  32'hFFFFFFF8, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{32'h400010B3, 1'b0, A_ADD, 5'd0,  5'd0,  5'd1,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h0020C1B3, 1'b0, A_XOR, 5'd1,  5'd2,  5'd3,  32'h00000000, 1'b0, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4));
      bus.ctrl_override = vecs[i].ovr;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.ctrl_override = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1000 + 32'(i * 4)) begin
        bad++; $display("FAIL decode[%0d] valid/pc: got %b/%h want 1/%h", i, bus.out_valid,
                        bus.out_pc, 32'h1000 + 32'(i * 4));
      end
      total++;
      if (bus.alu_funct !== vecs[i].alu || bus.illegal !== vecs[i].illegal) begin
        bad++; $display("FAIL decode[%0d] alu/illegal: got %0d/%b want %0d/%b", i,
                        bus.alu_funct, bus.illegal, vecs[i].alu, vecs[i].illegal);
      end
      total++;
      if (bus.rs1 !== vecs[i].rs1 || bus.rs2 !== vecs[i].rs2 || bus.rd !== vecs[i].rd) begin
        bad++; $display("FAIL decode[%0d] regs: got %0d/%0d/%0d want %0d/%0d/%0d", i, bus.rs1,
                        bus.rs2, bus.rd, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      end
      total++;
      if (bus.immed !== vecs[i].imm) begin
        bad++; $display("FAIL decode[%0d] immed: got %h want %h", i, bus.immed, vecs[i].imm);
      end
      total++;
      if (bus.use_imm !== vecs[i].use_imm || bus.rd_we !== vecs[i].rd_we) begin
        bad++; $display("FAIL decode[%0d] use_imm/rd_we: got %b/%b want %b/%b", i, bus.use_imm,
                        bus.rd_we, vecs[i].use_imm, vecs[i].rd_we);
      end
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL decode_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h00000013 | (32'(k + 1) << 7), 32'h2000 + 32'(k * 4));
      exp_q.push_back(32'h2000 + 32'(k * 4));
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_q[0] || bus.rd !== 5'(k + 1)) begin
        bad++; $display("FAIL stream[%0d]: valid=%b pc=%h rd=%0d want 1/%h/%0d", k, bus.out_valid,
                        bus.out_pc, bus.rd, exp_q[0], k + 1);
      end
      void'(exp_q.pop_front());
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h4000);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_a: got %b want 1", bus.in_ready); end
    @(negedge clk);
    drive(1'b1, 32'h00200113, 32'h4004);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_b: got %b want 1", bus.in_ready); end
    @(negedge clk);
    drive(1'b1, 32'h00300193, 32'h4008);
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h4000 || bus.rd !== 5'd1) begin
      bad++; $display("FAIL b2b_full: ready=%b pc=%h rd=%0d want 0/4000/1", bus.in_ready, bus.out_pc, bus.rd);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4000 || bus.immed !== 32'd1) begin
      bad++; $display("FAIL b2b_hold: ready=%b valid=%b pc=%h imm=%h want 0/1/4000/1", bus.in_ready,
                      bus.out_valid, bus.out_pc, bus.immed);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4004 || bus.rd !== 5'd2 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second: valid=%b pc=%h rd=%0d ready=%b want 1/4004/2/1", bus.out_valid,
                      bus.out_pc, bus.rd, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4008 || bus.rd !== 5'd3) begin
      bad++; $display("FAIL b2b_third: valid=%b pc=%h rd=%0d want 1/4008/3", bus.out_valid, bus.out_pc, bus.rd);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h3000);
    @(negedge clk);
    drive(1'b1, 32'h00200113, 32'h3004);
    @(negedge clk);
    drive(1'b1, 32'h00700393, 32'h3008);
    bus.flush = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_cleared: valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_dropped[%0d]: valid=%b pc=%h want 0", k, bus.out_valid, bus.out_pc);
      end
    end
    drive(1'b1, 32'h00400213, 32'h300C);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300C || bus.rd !== 5'd4) begin
      bad++; $display("FAIL flush_recover: valid=%b pc=%h rd=%0d want 1/300c/4", bus.out_valid, bus.out_pc, bus.rd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFF10093, 32'h5000);
    @(negedge clk);
    drive(1'b1, 32'h41F25193, 32'h5004);
    @(negedge clk);
    rst = 1'b1;
    bus.flush = 1'b1;
    drive(1'b1, 32'h00300193, 32'h5008);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.immed !== '0 || bus.rd !== 5'd0) begin
      bad++; $display("FAIL reset_mid: valid=%b pc=%h imm=%h rd=%0d want 0/0/0/0", bus.out_valid,
                      bus.out_pc, bus.immed, bus.rd);
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_idle: valid=%b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32I decode stage replacing the combinational decoder between fetch and execute. Decodes all five immediate formats (I/S/B/U/J) to XLEN-wide values, produces ALU function, register indices, write-enable and illegal-instruction flags. Buffers results in a 2-entry skid buffer under a valid/ready handshake, so execute-side back-pressure never creates a combinational path to fetch. Supports pipeline flush.

## Interface
Parameters:
- XLEN, 32, datapath/immediate/PC width (≥32)
- ALU_FUNCT_WIDTH, `ALU_FUNCT_WIDTH, width of alu_funct; encodings from alu_funct_defines.h

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and in-flight instructions
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts; `= !skid_valid && !flush`
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- ctrl_override  in  1  force alu_funct = ALU_FUNCT_ADD for this instruction
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute consumes entry
- out_pc  out  XLEN  PC of entry
- alu_funct  out  ALU_FUNCT_WIDTH  ALU operation
- rs1, rs2, rd  out  5 each  raw register fields
- immed  out  XLEN  extended immediate
- use_imm  out  1  ALU operand B is immed (not rs2)
- rd_we  out  1  writes rd (0 for STORE, BRANCH, illegal, rd==0)
- illegal  out  1  unsupported encoding

## Operation
- Decode is combinational on in_instr; results and in_pc are captured only on an accepted transfer (in_valid && in_ready).
- Opcodes: OP-IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Any other opcode → illegal.
- alu_funct: ADD unless opcode is OP/OP-IMM and ctrl_override=0. funct3 maps AND/OR/XOR/SLT/SLTU/SLL/SRL/ADD.
  - OP: funct7 0100000 selects SUB (f3=000) or SRA (f3=101); funct7 0000000 selects base. Any other funct7/funct3 combination → illegal.
  - OP-IMM: f3=000 is always ADD; funct7 is ignored. SLLI needs funct7=0; SRLI/SRAI need funct7 0000000/0100000, else illegal.
- immed, sign bit instr[31] replicated to XLEN:
  - I-type (LOAD, JALR, OP-IMM non-shift): instr[31:20]
  - shifts: instr[24:20] zero-extended
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - OP and illegal: 0
- use_imm=1 for all opcodes except OP and BRANCH.
- Illegal entries still flow through with illegal=1, alu_funct=ADD, immed=0, rd_we=0.
- Skid buffer: main entry (drives outputs) + skid entry.
  - Accept when main is empty or being consumed → write main.
  - Accept while main is held (out_valid && !out_ready) → write skid.
  - Main consumed while skid is valid → skid moves to main the same edge.
  - Order is strictly FIFO.
- flush: next edge clears both valid bits. Any transfer offered that cycle is dropped (in_ready=0). Data registers are don't-care.

## Timing
- Latency: accept at edge N → out_valid at edge N+1 when buffer empty. Throughput 1/cycle with out_ready=1.
- in_ready depends only on registered skid_valid and flush, never on out_ready.
- Reset: out_valid=0, skid_valid=0, all data outputs 0; in_ready=1 in the first cycle after rst deasserts. rst mid-transfer discards everything. rst overrides flush.
- Full: both entries valid → in_ready=0 until main is consumed. Skid refills main the same edge; in_ready returns to 1 the following cycle.
- Simultaneous consume + accept with skid empty: new entry replaces main, no bubble.
- out_* stable while out_valid && !out_ready.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), out_ready=1 → next cycle out_valid=1, alu=ADD, rs1=2, rd=1, immed=0xFFFFFFFF, use_imm=1, rd_we=1.
- 0x41F25193 (srai x3,x4,31) → alu=SRA, immed=0x0000001F, illegal=0. 0x40020093 (addi, funct7 set) → alu=ADD, immed=0x00000400.
- 0xFE532E23 (sw x5,-4(x6)) → immed=0xFFFFFFFC, rs1=6, rs2=5, rd_we=0. 0xFE000EE3 (beq x0,x0,-4) → immed=0xFFFFFFFC, use_imm=0.
- out_ready=0, offer A,B,C back-to-back → A,B accepted, in_ready=0 from cycle after B. Raise out_ready → A,B,C emerge in order, one per cycle, none lost or duplicated.
- Buffer full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, offered instruction never appears.
- 0x00000000 → illegal=1, rd_we=0, immed=0. ctrl_override=1 with 0x40000033 (sub) → alu=ADD.
